uart_tx_cfg: RTL and testbench

//   Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
//   - Data width is set at build time.
//   - Baud divisor, parity and stop-bit count are run-time configurable and latched per frame.
//   - Byte intake uses a valid/ready handshake.
//   - Sits between the TL-UL register block and the TX pin; an optional FIFO decouples bursts.
//

---
 rtl/uart_tx_cfg.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with run-time divisor/parity/stop config.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-word intake FIFO.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [DIV_W-1:0]     i_Clk_Div,
  input  logic                 i_Parity_En,
  input  logic                 i_Parity_Odd,
  input  logic                 i_Two_Stop,
  input  logic                 i_Tx_Valid,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done
);
  localparam int BW = $clog2(DATA_BITS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter values");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_en_q, par_en_d;
  logic                 par_q, par_d;
  logic                 two_q, two_d;

  logic                 have_word;
  logic [DATA_BITS-1:0] word;
  logic                 launch;
  logic                 tick;
  logic [DIV_W-1:0]     div_in;

  assign div_in = (i_Clk_Div < DIV_W'(2)) ? DIV_W'(2) : i_Clk_Div;
  assign tick   = (cnt_q == div_q - 1'b1);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit B2B = 1'b1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW:0]          fill_q, fill_d;
  logic                 push;

  assign o_Tx_Ready = !i_Reset && (fill_q != (AW+1)'(FIFO_DEPTH));
  assign push       = i_Tx_Valid && o_Tx_Ready;
  assign have_word  = (fill_q != '0);
  assign word       = mem_q[rd_q];

  // FIFO pointer and fill-level bookkeeping
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    if (push) wr_d = wr_q + 1'b1;
    if (launch) rd_d = rd_q + 1'b1;
    case ({push, launch})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_q] <= i_Tx_Data;
  end
`else
  localparam bit B2B = 1'b0;

  assign o_Tx_Ready = !i_Reset && (state_q == IDLE);
  assign have_word  = i_Tx_Valid;
  assign word       = i_Tx_Data;
`endif

  // Frame sequencing: next state, line level and per-frame config latch
  always_comb begin
    state_d  = state_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    two_d    = two_q;
    launch   = 1'b0;
    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        launch   = have_word;
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          serial_d = sh_q[0];
          sh_d     = sh_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d  = PARITY;
              serial_d = par_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 1'b1;
            serial_d = sh_q[0];
            sh_d     = sh_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (two_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            done_d   = 1'b1;
            state_d  = IDLE;
            serial_d = 1'b1;
            active_d = 1'b0;
            launch   = B2B && have_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d  = START;
      serial_d = 1'b0;
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = '0;
      sh_d     = word;
      div_d    = div_in;
      par_en_d = i_Parity_En;
      par_d    = (^word) ^ i_Parity_Odd;
      two_d    = i_Two_Stop;
    end
  end

  // FSM and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      two_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      two_q    <= two_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg.
// Line waveform is checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_cfg;
  localparam int DB = 8;
  localparam int DW = 16;
  localparam int FD = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] clk_div;
  logic          par_en, par_odd, two_stop;
  logic          valid;
  logic [DB-1:0] data;
  logic          ready, serial, active, done;

  int checks = 0;
  int failures = 0;
  bit exp_bits[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(DB), .DIV_W(DW), .FIFO_DEPTH(FD)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Clk_Div(clk_div),
    .i_Parity_En(par_en), .i_Parity_Odd(par_odd), .i_Two_Stop(two_stop),
    .i_Tx_Valid(valid), .i_Tx_Data(data), .o_Tx_Ready(ready),
    .o_Tx_Serial(serial), .o_Tx_Active(active), .o_Tx_Done(done)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int eff_div(input int cd);
    return (cd < 2) ? 2 : cd;
  endfunction

  // line levels of one frame, one entry per bit period
  task automatic build_bits(input logic [DB-1:0] d, input bit pen, input bit podd, input bit two);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
    if (pen) exp_bits.push_back((^d) ^ podd);
    exp_bits.push_back(1'b1);
    if (two) exp_bits.push_back(1'b1);
  endtask

  // send one word and record how the line matches the frame model
  task automatic run_frame(input logic [DB-1:0] d, input int cd, input bit pen,
                           input bit podd, input bit two, input bit scramble,
                           output int nerr, output int first_bad,
                           output int done_at, output bit tmo);
    int dv, f, off, w;
    bit es, ea, ed;
    dv = eff_div(cd);
    build_bits(d, pen, podd, two);
    f = dv * exp_bits.size();
    off = LAT - 1;
    nerr = 0; first_bad = -1; done_at = -1; tmo = 1'b0;
    @(negedge clk);
    clk_div = DW'(cd); par_en = pen; par_odd = podd; two_stop = two;
    data = d; valid = 1'b1;
    w = 0;
    while (!ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      tmo = 1'b1;
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 valid = 1'b0;
    for (int k = 0; k <= off + f; k++) begin
      @(negedge clk);
      ea = (k >= off) && (k < off + f);
      es = ea ? exp_bits[(k - off) / dv] : 1'b1;
      ed = (k == off + f);
      if (serial !== es || active !== ea || done !== ed) begin
        nerr++;
        if (first_bad < 0) first_bad = k;
      end
      if (done === 1'b1 && done_at < 0) done_at = k - off;
      if (scramble) begin
        clk_div = DW'($urandom_range(0, 7));
        par_en = 1'($urandom); par_odd = 1'($urandom);
        two_stop = 1'($urandom); data = DB'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; data = '0;
    clk_div = DW'(4); par_en = 0; par_odd = 0; two_stop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (serial !== 1'b1) begin failures++; $display("FAIL reset_serial got=%b want=1", serial); end
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", active); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready); end
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b want=1", ready); end
  endtask

  task automatic test_known();
    int ne, fb, da;
    bit to;
    run_frame(8'hA5, 4, 0, 0, 0, 0, ne, fb, da, to);
    checks++;
    if (to || ne != 0) begin
      failures++;
      $display("FAIL vec_a5_wave got=%0d bad cycles (first %0d, tmo %0b) want=0", ne, fb, to);
    end
    checks++;
    if (da != 40) begin failures++; $display("FAIL vec_a5_done got=%0d want=40", da); end
    run_frame(8'h03, 4, 1, 1, 1, 0, ne, fb, da, to);
    checks++;
    if (to || ne != 0) begin
      failures++;
      $display("FAIL vec_03_wave got=%0d bad cycles (first %0d, tmo %0b) want=0", ne, fb, to);
    end
    checks++;
    if (da != 48) begin failures++; $display("FAIL vec_03_done got=%0d want=48", da); end
  endtask

  task automatic test_clk_div();
    int ne, fb, da;
    bit to;
    for (int cd = 0; cd < 2; cd++) begin
      run_frame(DB'($urandom), cd, 0, 0, 0, 1, ne, fb, da, to);
      checks++;
      if (to || ne != 0) begin
        failures++;
        $display("FAIL div%0d_wave got=%0d bad cycles (first %0d) want=0", cd, ne, fb);
      end
      checks++;
      if (da != 20) begin failures++; $display("FAIL div%0d_done got=%0d want=20", cd, da); end
    end
  endtask

  task automatic test_random();
    int ne, fb, da, cd, want;
    bit to, pen, podd, two;
    logic [DB-1:0] d;
    for (int n = 0; n < 16; n++) begin
      d = DB'($urandom); cd = $urandom_range(0, 6);
      pen = 1'($urandom); podd = 1'($urandom); two = 1'($urandom);
      run_frame(d, cd, pen, podd, two, 1, ne, fb, da, to);
      want = eff_div(cd) * (1 + DB + int'(pen) + 1 + int'(two));
      checks++;
      if (to || ne != 0 || da != want) begin
        failures++;
        $display("FAIL rand%0d d=%h div=%0d p=%0b o=%0b s2=%0b got=%0d bad/done %0d want=0/%0d",
                 n, d, cd, pen, podd, two, ne, da, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w, lows, dones, ne, fb, da;
    bit to;
    @(negedge clk);
    clk_div = DW'(4); par_en = 0; par_odd = 0; two_stop = 0;
    data = DB'($urandom); valid = 1'b1;
    w = 0;
    while (!ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (serial !== 1'b1 || active !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=s%b a%b r%b want=s1 a0 r0", serial, active, ready);
    end
    rst = 1'b0;
    lows = 0; dones = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (serial !== 1'b1) lows++;
      if (done !== 1'b0) dones++;
    end
    checks++;
    if (lows != 0 || dones != 0) begin
      failures++;
      $display("FAIL mid_reset_quiet got=%0d low %0d done want=0 0", lows, dones);
    end
    run_frame(DB'($urandom), 3, 1, 0, 0, 0, ne, fb, da, to);
    checks++;
    if (to || ne != 0) begin
      failures++;
      $display("FAIL after_reset_frame got=%0d bad (first %0d, tmo %0b) want=0", ne, fb, to);
    end
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_back_to_back();
    bit q1[$], q2[$];
    int dv, f, w, ne, nr, fb;
    bit phase, es, ea, ed, er, pen, podd, two;
    logic [DB-1:0] d1, d2;
    d1 = DB'($urandom); d2 = DB'($urandom);
    dv = $urandom_range(2, 5);
    pen = 1'($urandom); podd = 1'($urandom); two = 1'($urandom);
    build_bits(d1, pen, podd, two); q1 = exp_bits;
    build_bits(d2, pen, podd, two); q2 = exp_bits;
    f = dv * q1.size();
    @(negedge clk);
    clk_div = DW'(dv); par_en = pen; par_odd = podd; two_stop = two;
    data = d1; valid = 1'b1;
    w = 0;
    while (!ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 data = d2;
    phase = 0; ne = 0; nr = 0; fb = -1;
    for (int k = 0; k < 2 * f + 2; k++) begin
      @(negedge clk);
      if (k < f) begin
        es = q1[k / dv]; ea = 1; ed = 0; er = 0;
      end else if (k == f || k == 2 * f + 1) begin
        es = 1; ea = 0; ed = 1; er = 1;
      end else begin
        es = q2[(k - f - 1) / dv]; ea = 1; ed = 0; er = 0;
      end
      if (serial !== es || active !== ea || done !== ed) begin
        ne++;
        if (fb < 0) fb = k;
      end
      if (ready !== er) nr++;
      if (phase == 0 && ready) begin
        phase = 1;
        @(posedge clk);
        #1 valid = 1'b0;
      end
    end
    valid = 1'b0;
    checks++;
    if (ne != 0) begin
      failures++;
      $display("FAIL b2b_wave got=%0d bad cycles (first %0d) want=0", ne, fb);
    end
    checks++;
    if (nr != 0) begin failures++; $display("FAIL b2b_ready got=%0d bad cycles want=0", nr); end
    checks++;
    if (phase != 1) begin failures++; $display("FAIL b2b_second_accept got=%0b want=1", phase); end
  endtask
`else
  task automatic test_fifo_burst();
    logic [DB-1:0] wd [6];
    int dv, f, idx, k, stall, ne, fb, nd, j;
    bit started, acc, es, ea, ed;
    dv = 2;
    for (int i = 0; i < 6; i++) wd[i] = DB'($urandom);
    build_bits(8'h00, 0, 0, 0);
    f = dv * exp_bits.size();
    @(negedge clk);
    clk_div = DW'(dv); par_en = 0; par_odd = 0; two_stop = 0;
    data = wd[0]; valid = 1'b1;
    idx = 0; k = 0; stall = -1; ne = 0; fb = -1; nd = 0; started = 0;
    for (int cyc = 0; cyc < 400 && k < 6 * f + 2; cyc++) begin
      @(negedge clk);
      if (started) begin
        if (k == 0 || k > 6 * f) begin
          es = 1; ea = 0; ed = (k > 6 * f);
        end else begin
          j = k - 1;
          build_bits(wd[j / f], 0, 0, 0);
          es = exp_bits[(j % f) / dv]; ea = 1; ed = (j > 0 && j % f == 0);
        end
        if (serial !== es || active !== ea || done !== ed) begin
          ne++;
          if (fb < 0) fb = k;
        end
        if (done === 1'b1) nd++;
        k++;
      end
      if (idx < 6 && !ready && stall < 0) stall = idx;
      acc = (idx < 6) && ready;
      @(posedge clk);
      if (acc) begin
        idx++;
        started = 1;
      end
      #1;
      if (idx < 6) data = wd[idx];
      else valid = 1'b0;
    end
    valid = 1'b0;
    checks++;
    if (stall != FD + 1) begin failures++; $display("FAIL fifo_stall got=%0d want=%0d", stall, FD + 1); end
    checks++;
    if (idx != 6) begin failures++; $display("FAIL fifo_accepts got=%0d want=6", idx); end
    checks++;
    if (ne != 0 || k != 6 * f + 2) begin
      failures++;
      $display("FAIL fifo_wave got=%0d bad (first %0d, samples %0d) want=0", ne, fb, k);
    end
    checks++;
    if (nd != 6) begin failures++; $display("FAIL fifo_done_count got=%0d want=6", nd); end
  endtask
`endif

  initial begin
    test_reset();
    test_known();
    test_clk_div();
    test_random();
    test_reset_mid();
`ifndef UART_TX_FIFO_EN
    test_back_to_back();
`else
    test_fifo_burst();
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
